branch_compare_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the 16-bit single-result comparator.
- Compares two WIDTH-bit operands under a selectable mode: EQ, NE, signed LT/GE, unsigned LTU/GEU.
- Returns a taken flag plus raw eq/lt/ltu flags, using valid/ready handshakes and a pipeline flush.
- Sits in the ID/EX branch-resolution path and carries an opaque tag (e.g. ROB/PC index) alongside each result.

---
 rtl/cmp_pkg.sv | 20 ++
 rtl/cmp_chunk.sv | 14 +
 rtl/branch_compare_pipe.sv | 171 +++++++++++++++++
 tb/tb_branch_compare_pipe.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared compare-mode encodings and helpers for the branch comparator pipeline.
package cmp_pkg;

    localparam int unsigned CMP_MODE_W = 3;

    typedef enum logic [CMP_MODE_W-1:0] {
        CMP_EQ  = 3'b000,
        CMP_NE  = 3'b001,
        CMP_LT  = 3'b100,
        CMP_GE  = 3'b101,
        CMP_LTU = 3'b110,
        CMP_GEU = 3'b111
    } cmp_mode_e;

    // Encodings 010 and 011 have no defined comparison.
    function automatic logic mode_is_reserved(input logic [CMP_MODE_W-1:0] m);
        return (m[2:1] == 2'b01);
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// One CHUNK_W-bit slice of the comparator: equality and unsigned less-than.
module cmp_chunk #(
    parameter int unsigned CHUNK_W = 4
) (
    input  logic [CHUNK_W-1:0] i_a,
    input  logic [CHUNK_W-1:0] i_b,
    output logic               o_eq,
    output logic               o_ltu
);

    assign o_eq  = (i_a == i_b);
    assign o_ltu = (i_a < i_b);

endmodule

// File: rtl/branch_compare_pipe.sv
// Two-stage pipelined branch comparator: stage 1 registers per-chunk eq/ltu,
// stage 2 combines them and evaluates the mode, with valid/ready and flush.
module branch_compare_pipe
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CHUNK_W = 4,
    parameter int unsigned TAG_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [CMP_MODE_W-1:0] mode,
    input  logic [TAG_W-1:0]      tag_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  taken,
    output logic                  eq,
    output logic                  lt,
    output logic                  ltu,
    output logic                  bad_mode,
    output logic [TAG_W-1:0]      tag_out
);

    if (CHUNK_W == 0 || WIDTH == 0 || (WIDTH % CHUNK_W) != 0) begin : g_bad_width
        $error("branch_compare_pipe: WIDTH must be a non-zero multiple of CHUNK_W");
    end

    localparam int unsigned NCH = WIDTH / CHUNK_W;

    logic [NCH-1:0]        w_ch_eq;
    logic [NCH-1:0]        w_ch_ltu;

    logic                  r_s1_valid;
    logic [NCH-1:0]        r_s1_eq;
    logic [NCH-1:0]        r_s1_ltu;
    logic                  r_s1_sa;
    logic                  r_s1_sb;
    logic [CMP_MODE_W-1:0] r_s1_mode;
    logic [TAG_W-1:0]      r_s1_tag;

    logic                  r_s2_valid;
    logic                  r_taken;
    logic                  r_eq;
    logic                  r_lt;
    logic                  r_ltu;
    logic                  r_bad;
    logic [TAG_W-1:0]      r_tag;

    logic                  w_s2_adv;
    logic                  w_s1_adv;
    logic                  w_accept;
    logic                  w_s2_load;
    logic                  w_eq;
    logic                  w_ltu;
    logic                  w_lt;
    logic                  w_bad;
    logic                  w_taken;

    for (genvar k = 0; k < NCH; k++) begin : g_chunk
        cmp_chunk #(
            .CHUNK_W(CHUNK_W)
        ) u_chunk (
            .i_a  (a[k*CHUNK_W +: CHUNK_W]),
            .i_b  (b[k*CHUNK_W +: CHUNK_W]),
            .o_eq (w_ch_eq[k]),
            .o_ltu(w_ch_ltu[k])
        );
    end

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = rst_n && w_s1_adv && !flush;
    assign w_accept  = in_valid && in_ready;
    assign w_s2_load = r_s1_valid && w_s2_adv && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_eq    <= '0;
            r_s1_ltu   <= '0;
            r_s1_sa    <= 1'b0;
            r_s1_sb    <= 1'b0;
            r_s1_mode  <= '0;
            r_s1_tag   <= '0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_adv) begin
                r_s1_valid <= w_accept;
            end
            if (w_accept) begin
                r_s1_eq   <= w_ch_eq;
                r_s1_ltu  <= w_ch_ltu;
                r_s1_sa   <= a[WIDTH-1];
                r_s1_sb   <= b[WIDTH-1];
                r_s1_mode <= mode;
                r_s1_tag  <= tag_in;
            end
        end
    end

    // The highest-indexed unequal chunk is the last to write w_ltu, so it decides.
    always_comb begin
        w_eq  = &r_s1_eq;
        w_ltu = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!r_s1_eq[k]) begin
                w_ltu = r_s1_ltu[k];
            end
        end
        w_lt    = (r_s1_sa != r_s1_sb) ? r_s1_sa : w_ltu;
        w_bad   = mode_is_reserved(r_s1_mode);
        w_taken = 1'b0;
        case (r_s1_mode)
            CMP_EQ:  w_taken = w_eq;
            CMP_NE:  w_taken = !w_eq;
            CMP_LT:  w_taken = w_lt;
            CMP_GE:  w_taken = !w_lt;
            CMP_LTU: w_taken = w_ltu;
            CMP_GEU: w_taken = !w_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_taken    <= 1'b0;
            r_eq       <= 1'b0;
            r_lt       <= 1'b0;
            r_ltu      <= 1'b0;
            r_bad      <= 1'b0;
            r_tag      <= '0;
        end else begin
            if (flush) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_load) begin
                r_taken <= w_taken;
                r_eq    <= w_eq;
                r_lt    <= w_lt;
                r_ltu   <= w_ltu;
                r_bad   <= w_bad;
                r_tag   <= r_s1_tag;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign taken     = r_taken;
    assign eq        = r_eq;
    assign lt        = r_lt;
    assign ltu       = r_ltu;
    assign bad_mode  = r_bad;
    assign tag_out   = r_tag;

    property p_hold_while_stalled;
        @(posedge clk) disable iff (!rst_n)
            (out_valid && !out_ready && !flush)
            |=> (out_valid && $stable({taken, eq, lt, ltu, bad_mode, tag_out}));
    endproperty
    a_hold_while_stalled: assert property (p_hold_while_stalled);

endmodule

// File: tb/tb_branch_compare_pipe.sv
// Bench for branch_compare_pipe: vector tables, hand-written handshake/flush/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_branch_compare_pipe;
    import cmp_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  mode;
        logic [3:0]  tag;
        logic        taken;
        logic        eq;
        logic        lt;
        logic        ltu;
        logic        bad;
    } vec_t;

    typedef struct packed {
        logic       ov;
        logic       ir;
        logic       taken;
        logic       eq;
        logic       lt;
        logic       ltu;
        logic       bad;
        logic [3:0] tag;
    } out_t;

    typedef struct {
        logic       taken;
        logic       eq;
        logic       lt;
        logic       ltu;
        logic       bad;
        logic [3:0] tag;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, out_ready;
    logic [2:0]  mode;
    logic [3:0]  tag_in;

    logic        in_valid16, in_ready16, out_valid16, taken16, eq16, lt16, ltu16, bad16;
    logic [15:0] a16, b16;
    logic [3:0]  tag16;

    logic        in_valid32, in_ready32, out_valid32, taken32, eq32, lt32, ltu32, bad32;
    logic [31:0] a32, b32;
    logic [3:0]  tag32;

    int errors = 0;
    int checks = 0;

    vec_t tbl16[13];
    vec_t tbl32[6];
    exp_t q[$];

    branch_compare_pipe u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .mode(mode), .tag_in(tag_in), .flush(flush),
        .out_valid(out_valid16), .out_ready(out_ready), .taken(taken16), .eq(eq16),
        .lt(lt16), .ltu(ltu16), .bad_mode(bad16), .tag_out(tag16)
    );

    branch_compare_pipe #(.WIDTH(32), .CHUNK_W(8), .TAG_W(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .mode(mode), .tag_in(tag_in), .flush(flush),
        .out_valid(out_valid32), .out_ready(out_ready), .taken(taken32), .eq(eq32),
        .lt(lt32), .ltu(ltu32), .bad_mode(bad32), .tag_out(tag32)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic [2:0] m, logic [3:0] t,
                                logic tk, logic e, logic l, logic lu, logic bd);
        vec_t v;
        v.a = a; v.b = b; v.mode = m; v.tag = t;
        v.taken = tk; v.eq = e; v.lt = l; v.ltu = lu; v.bad = bd;
        return v;
    endfunction

    function automatic out_t get_out(bit wide);
        out_t o;
        if (wide) o = '{out_valid32, in_ready32, taken32, eq32, lt32, ltu32, bad32, tag32};
        else      o = '{out_valid16, in_ready16, taken16, eq16, lt16, ltu16, bad16, tag16};
        return o;
    endfunction

    task automatic drive(input bit wide, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] m, input logic [3:0] t);
        if (wide) begin
            in_valid32 = v; a32 = a; b32 = b; in_valid16 = 1'b0;
        end else begin
            in_valid16 = v; a16 = a[15:0]; b16 = b[15:0]; in_valid32 = 1'b0;
        end
        mode = m;
        tag_in = t;
    endtask

    // Compare semantics straight from the mode table, using native arithmetic.
    function automatic exp_t ref16(logic [15:0] a, logic [15:0] b, logic [2:0] m, logic [3:0] t);
        exp_t r;
        r.eq  = (a == b);
        r.ltu = (a < b);
        r.lt  = ($signed(a) < $signed(b));
        r.bad = (m == 3'b010) || (m == 3'b011);
        r.tag = t;
        r.acc = 0;
        case (m)
            3'b000:  r.taken = r.eq;
            3'b001:  r.taken = !r.eq;
            3'b100:  r.taken = r.lt;
            3'b101:  r.taken = !r.lt;
            3'b110:  r.taken = r.ltu;
            3'b111:  r.taken = !r.ltu;
            default: r.taken = 1'b0;
        endcase
        return r;
    endfunction

    task automatic run_table(input bit wide);
        int   n;
        vec_t v;
        out_t o;
        n = wide ? 6 : 13;
        out_ready = 1'b1;
        flush = 1'b0;
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                v = wide ? tbl32[i] : tbl16[i];
                drive(wide, 1'b1, v.a, v.b, v.mode, v.tag);
            end else begin
                drive(wide, 1'b0, '0, '0, 3'b000, 4'h0);
            end
            #1;
            o = get_out(wide);
            check("tbl_in_ready", o.ir, 1);
            if (i >= 2) begin
                v = wide ? tbl32[i-2] : tbl16[i-2];
                check("tbl_out_valid", o.ov, 1);
                check("tbl_taken", o.taken, v.taken);
                check("tbl_eq", o.eq, v.eq);
                check("tbl_lt", o.lt, v.lt);
                check("tbl_ltu", o.ltu, v.ltu);
                check("tbl_bad_mode", o.bad, v.bad);
                check("tbl_tag", o.tag, v.tag);
            end else begin
                check("tbl_latency_no_early_valid", o.ov, 0);
            end
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t o;
        int   idx;
        int   exp_tags[3];
        int   cyc;
        logic model_ready, model_ov;
        logic [15:0] ra, rb;
        logic [2:0]  rm;
        logic [3:0]  rt;
        exp_t e;

        tbl16[0]  = mk(32'h1,    32'h2,    CMP_EQ,  4'd1,  0, 0, 1, 1, 0);
        tbl16[1]  = mk(32'h1,    32'h1,    CMP_EQ,  4'd2,  1, 1, 0, 0, 0);
        tbl16[2]  = mk(32'h1,    32'h3,    CMP_LTU, 4'd3,  1, 0, 1, 1, 0);
        tbl16[3]  = mk(32'h7,    32'h3,    CMP_GEU, 4'd4,  1, 0, 0, 0, 0);
        tbl16[4]  = mk(32'hFFFF, 32'h0001, CMP_LT,  4'd5,  1, 0, 1, 0, 0);
        tbl16[5]  = mk(32'hFFFF, 32'h0001, CMP_LTU, 4'd6,  0, 0, 1, 0, 0);
        tbl16[6]  = mk(32'h5,    32'h5,    3'b010,  4'd7,  0, 1, 0, 0, 1);
        tbl16[7]  = mk(32'h5,    32'h5,    3'b011,  4'd8,  0, 1, 0, 0, 1);
        tbl16[8]  = mk(32'h1234, 32'h1234, CMP_NE,  4'd9,  0, 1, 0, 0, 0);
        tbl16[9]  = mk(32'h8000, 32'h7FFF, CMP_GE,  4'd10, 0, 0, 1, 0, 0);
        tbl16[10] = mk(32'h7FFF, 32'h8000, CMP_GE,  4'd11, 1, 0, 0, 1, 0);
        tbl16[11] = mk(32'h1200, 32'h1300, CMP_LT,  4'd12, 1, 0, 1, 1, 0);
        tbl16[12] = mk(32'h0010, 32'h0001, CMP_LTU, 4'd13, 0, 0, 0, 0, 0);

        tbl32[0] = mk(32'h1,        32'h2,        CMP_EQ,  4'd1, 0, 0, 1, 1, 0);
        tbl32[1] = mk(32'h1,        32'h1,        CMP_EQ,  4'd2, 1, 1, 0, 0, 0);
        tbl32[2] = mk(32'h1,        32'h3,        CMP_LTU, 4'd3, 1, 0, 1, 1, 0);
        tbl32[3] = mk(32'h7,        32'h3,        CMP_GEU, 4'd4, 1, 0, 0, 0, 0);
        tbl32[4] = mk(32'h80000000, 32'h7FFFFFFF, CMP_LT,  4'd5, 1, 0, 1, 0, 0);
        tbl32[5] = mk(32'h00010000, 32'h0000FFFF, CMP_LTU, 4'd6, 0, 0, 0, 0, 0);

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid16 = 1'b0; in_valid32 = 1'b0;
        a16 = '0; b16 = '0; a32 = '0; b32 = '0; mode = '0; tag_in = '0;

        #12;
        o = get_out(1'b0);
        check("reset_out_valid", o.ov, 0);
        check("reset_in_ready", o.ir, 0);
        check("reset_taken", o.taken, 0);
        check("reset_eq", o.eq, 0);
        check("reset_tag", o.tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_table(1'b0);

        // Backpressure: two results held, third op stalls, drain in order.
        out_ready = 1'b0;
        drive(1'b0, 1'b1, 32'h1, 32'h2, CMP_LTU, 4'd1); #1;
        check("bp_ready_first", in_ready16, 1); step();
        drive(1'b0, 1'b1, 32'h7, 32'h3, CMP_GEU, 4'd2); #1;
        check("bp_ready_second", in_ready16, 1); step();
        drive(1'b0, 1'b1, 32'h5, 32'h5, CMP_EQ, 4'd3);
        for (int s = 0; s < 3; s++) begin
            #1;
            o = get_out(1'b0);
            check("bp_full_in_ready", o.ir, 0);
            check("bp_hold_valid", o.ov, 1);
            check("bp_hold_tag", o.tag, 1);
            check("bp_hold_taken", o.taken, 1);
            check("bp_hold_eq", o.eq, 0);
            check("bp_hold_lt", o.lt, 1);
            check("bp_hold_ltu", o.ltu, 1);
            step();
        end
        out_ready = 1'b1;
        exp_tags = '{1, 2, 3};
        idx = 0;
        for (int j = 0; j < 8; j++) begin
            if (j == 1) in_valid16 = 1'b0;
            #1;
            if (j == 0) check("bp_ready_after_release", in_ready16, 1);
            if (out_valid16) begin
                if (idx < 3) check("bp_drain_tag", tag16, exp_tags[idx]);
                else check("bp_drain_duplicate", 1, 0);
                idx++;
            end
            step();
        end
        check("bp_drain_count", idx, 3);

        // Flush with two entries held and an op offered in the flush cycle.
        out_ready = 1'b0;
        drive(1'b0, 1'b1, 32'h5, 32'h5, CMP_EQ, 4'd3); #1;
        check("fl_ready_a", in_ready16, 1); step();
        drive(1'b0, 1'b1, 32'h5, 32'h6, CMP_EQ, 4'd4); #1;
        check("fl_ready_b", in_ready16, 1); step();
        drive(1'b0, 1'b1, 32'h9, 32'h9, CMP_EQ, 4'd9);
        flush = 1'b1; #1;
        check("fl_in_ready_during_flush", in_ready16, 0);
        check("fl_valid_before_flush", out_valid16, 1);
        step();
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 1'b1, 32'h1, 32'h2, CMP_LT, 4'd5); #1;
        check("fl_out_valid_after", out_valid16, 0);
        check("fl_ready_after", in_ready16, 1);
        step();
        in_valid16 = 1'b0; #1;
        check("fl_tag5_not_early", out_valid16, 0);
        step(); #1;
        check("fl_tag5_valid", out_valid16, 1);
        check("fl_tag5_tag", tag16, 5);
        check("fl_tag5_taken", taken16, 1);
        step(); #1;
        check("fl_no_ghost", out_valid16, 0);
        step();

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        drive(1'b0, 1'b1, 32'h5, 32'h5, CMP_EQ, 4'hF); step();
        drive(1'b0, 1'b1, 32'h5, 32'h5, CMP_EQ, 4'hE); step();
        in_valid16 = 1'b0; #1;
        check("ar_full_valid", out_valid16, 1);
        check("ar_full_tag", tag16, 4'hF);
        #1;
        rst_n = 1'b0; #1;
        o = get_out(1'b0);
        check("ar_out_valid", o.ov, 0);
        check("ar_taken", o.taken, 0);
        check("ar_eq", o.eq, 0);
        check("ar_tag", o.tag, 0);
        check("ar_in_ready", o.ir, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 32'h1, 32'h1, CMP_EQ, 4'd6); #1;
        check("ar_first_accept_ready", in_ready16, 1);
        check("ar_dropped_s1", out_valid16, 0);
        step();
        in_valid16 = 1'b0; #1;
        check("ar_no_early", out_valid16, 0);
        step(); #1;
        check("ar_post_valid", out_valid16, 1);
        check("ar_post_tag", tag16, 6);
        check("ar_post_taken", taken16, 1);
        out_ready = 1'b1;
        step(); #1;
        check("ar_no_stale_entry", out_valid16, 0);
        step();

        // Randomized traffic against the queue model.
        q.delete();
        cyc = 0;
        for (int n = 0; n < 2000; n++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            if ($urandom_range(0, 3) == 0) rb = ra ^ 16'(1 << $urandom_range(0, 15));
            rm = 3'($urandom);
            rt = 4'($urandom);
            drive(1'b0, ($urandom_range(0, 3) != 0), {16'h0, ra}, {16'h0, rb}, rm, rt);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            #1;
            model_ready = !flush && ((q.size() < 2) || out_ready);
            model_ov = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
            check("rnd_in_ready", in_ready16, model_ready);
            check("rnd_out_valid", out_valid16, model_ov);
            if (model_ov && out_ready) begin
                e = q.pop_front();
                check("rnd_taken", taken16, e.taken);
                check("rnd_eq", eq16, e.eq);
                check("rnd_lt", lt16, e.lt);
                check("rnd_ltu", ltu16, e.ltu);
                check("rnd_bad_mode", bad16, e.bad);
                check("rnd_tag", tag16, e.tag);
            end
            if (flush) begin
                q.delete();
            end else if (in_valid16 && model_ready) begin
                e = ref16(ra, rb, rm, rt);
                e.acc = cyc;
                q.push_back(e);
            end
            step();
            cyc++;
        end
        in_valid16 = 1'b0; flush = 1'b0; out_ready = 1'b1;
        step(); step(); step();

        run_table(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
